pc_next_seq: RTL and testbench

Next-address generator that sits directly upstream of the 8-bit program-counter register. It takes the current PC value back from that register, plus control from the decoder. It produces the 8-bit next address that the register loads on every clock edge. It holds a small hardware return-address stack for CALL/RET and sticky error flags for stack overflow and underflow.

---
 rtl/pc_next_seq.sv | 91 +++++++++
 tb/tb_pc_next_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/pc_next_seq.sv
// rtl/pc_next_seq.sv - next-PC generator with return-address stack and sticky overflow/underflow flags
module pc_next_seq #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [AW-1:0]          PC_IN,
  input  logic [AW-1:0]          TARGET,
  input  logic                   JUMP,
  input  logic                   CALL,
  input  logic                   RET,
  input  logic                   STALL,
  input  logic                   CLR_FLAGS,
  output logic [AW-1:0]          NEXT_PC,
  output logic [$clog2(DEPTH):0] SP,
  output logic                   STK_OVF,
  output logic                   STK_UNF
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  logic [AW-1:0] r_stack [DEPTH];
  logic [SW-1:0] r_sp;
  logic          r_ovf;
  logic          r_unf;

  logic [AW-1:0] w_pc_inc;
  logic [SW-1:0] w_sp_m1;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_push_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_unf_evt;
  logic          w_ovf_evt;

  assign w_pc_inc   = PC_IN + AW'(1);
  assign w_sp_m1    = r_sp - SW'(1);
  assign w_top_idx  = w_sp_m1[IW-1:0];
  assign w_push_idx = r_sp[IW-1:0];
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == SW'(DEPTH));

  // RET outranks CALL, so push and pop are mutually exclusive in any cycle.
  assign w_pop     = !STALL && RET && !w_empty;
  assign w_unf_evt = !STALL && RET && w_empty;
  assign w_push    = !STALL && !RET && CALL && !w_full;
  assign w_ovf_evt = !STALL && !RET && CALL && w_full;

  always_comb begin
    NEXT_PC = w_pc_inc;
    if (!RESET) begin
      NEXT_PC = '0;
    end else if (STALL) begin
      NEXT_PC = PC_IN;
    end else if (RET) begin
      NEXT_PC = w_empty ? w_pc_inc : r_stack[w_top_idx];
    end else if (CALL || JUMP) begin
      NEXT_PC = TARGET;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_stack[w_push_idx] <= w_pc_inc;
        r_sp                <= r_sp + SW'(1);
      end else if (w_pop) begin
        r_sp <= w_sp_m1;
      end
      // A set event in the same cycle as CLR_FLAGS leaves the flag set.
      r_ovf <= w_ovf_evt || (r_ovf && !CLR_FLAGS);
      r_unf <= w_unf_evt || (r_unf && !CLR_FLAGS);
    end
  end

  assign SP      = r_sp;
  assign STK_OVF = r_ovf;
  assign STK_UNF = r_unf;

endmodule

// File: tb/tb_pc_next_seq.sv
// tb/tb_pc_next_seq.sv - table-driven bench for pc_next_seq
module tb_pc_next_seq;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] PC_IN, TARGET;
  logic       JUMP, CALL, RET, STALL, CLR_FLAGS;
  logic [7:0] NEXT_PC;
  logic [2:0] SP;
  logic       STK_OVF, STK_UNF;

  int n_tests = 0;
  int n_fail  = 0;

  pc_next_seq #(.AW(8), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .PC_IN(PC_IN), .TARGET(TARGET),
    .JUMP(JUMP), .CALL(CALL), .RET(RET), .STALL(STALL), .CLR_FLAGS(CLR_FLAGS),
    .NEXT_PC(NEXT_PC), .SP(SP), .STK_OVF(STK_OVF), .STK_UNF(STK_UNF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [7:0] pc;
    logic [7:0] tgt;
    logic       j, c, r, s, clr;
    logic [7:0] nx;
    logic [2:0] sp;
    logic       ovf, unf;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle: NEXT_PC checked before the edge, registered outputs after it.
  task automatic run_vec(input vec_t v, input int idx);
    RESET = v.rst; PC_IN = v.pc; TARGET = v.tgt;
    JUMP = v.j; CALL = v.c; RET = v.r; STALL = v.s; CLR_FLAGS = v.clr;
    #1;
    chk("next_pc", idx, NEXT_PC, v.nx);
    @(posedge CLK); #1;
    chk("sp", idx, {5'b0, SP}, {5'b0, v.sp});
    chk("stk_ovf", idx, {7'b0, STK_OVF}, {7'b0, v.ovf});
    chk("stk_unf", idx, {7'b0, STK_UNF}, {7'b0, v.unf});
  endtask

  task automatic add(input logic rst, input logic [7:0] pc, input logic [7:0] tgt,
                     input logic j, input logic c, input logic r, input logic s, input logic clr,
                     input logic [7:0] nx, input logic [2:0] sp, input logic ovf, input logic unf);
    vec_t v;
    v.rst = rst; v.pc = pc; v.tgt = tgt; v.j = j; v.c = c; v.r = r; v.s = s; v.clr = clr;
    v.nx = nx; v.sp = sp; v.ovf = ovf; v.unf = unf;
    vt.push_back(v);
  endtask

  initial begin
    RESET = 1'b0; PC_IN = 8'h00; TARGET = 8'h00;
    JUMP = 1'b0; CALL = 1'b0; RET = 1'b0; STALL = 1'b0; CLR_FLAGS = 1'b0;

    //   rst pc     tgt    j  c  r  s  clr  nx     sp ovf unf
    add(0, 8'h10, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 8'h10, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h10, 8'h00, 0, 0, 0, 0, 0, 8'h11, 0, 0, 0);
    add(1, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 8'h40, 0, 1, 0, 0, 0, 8'h40, 1, 0, 0);
    add(1, 8'h40, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h01, 8'h80, 0, 1, 0, 0, 0, 8'h80, 1, 0, 0);
    add(1, 8'h11, 8'h80, 0, 1, 0, 0, 0, 8'h80, 2, 0, 0);
    add(1, 8'h21, 8'h80, 0, 1, 0, 0, 0, 8'h80, 3, 0, 0);
    add(1, 8'h31, 8'h80, 0, 1, 0, 0, 0, 8'h80, 4, 0, 0);
    add(1, 8'h41, 8'h80, 0, 1, 0, 0, 0, 8'h80, 4, 1, 0);
    add(1, 8'h80, 8'h00, 0, 0, 1, 0, 0, 8'h32, 3, 1, 0);
    add(1, 8'h32, 8'h00, 0, 0, 1, 0, 0, 8'h22, 2, 1, 0);
    add(1, 8'h22, 8'h00, 0, 0, 1, 0, 0, 8'h12, 1, 1, 0);
    add(1, 8'h12, 8'h00, 0, 0, 1, 0, 0, 8'h02, 0, 1, 0);
    add(1, 8'h55, 8'h00, 0, 0, 1, 0, 0, 8'h56, 0, 1, 1);
    add(1, 8'h56, 8'h00, 0, 0, 0, 0, 1, 8'h57, 0, 0, 0);
    add(1, 8'h57, 8'h00, 0, 0, 1, 0, 1, 8'h58, 0, 0, 1);
    add(1, 8'h58, 8'h00, 0, 0, 0, 0, 1, 8'h59, 0, 0, 0);
    add(1, 8'h22, 8'h90, 0, 1, 0, 0, 0, 8'h90, 1, 0, 0);
    add(1, 8'h30, 8'h90, 0, 1, 1, 1, 0, 8'h30, 1, 0, 0);
    add(1, 8'h30, 8'h90, 0, 1, 1, 0, 0, 8'h23, 0, 0, 0);
    add(1, 8'h60, 8'h70, 1, 1, 0, 0, 0, 8'h70, 1, 0, 0);
    add(1, 8'h70, 8'h00, 0, 0, 1, 0, 0, 8'h61, 0, 0, 0);
    add(1, 8'h10, 8'hA5, 1, 0, 0, 0, 0, 8'hA5, 0, 0, 0);
    add(1, 8'h33, 8'h00, 0, 0, 1, 0, 0, 8'h34, 0, 0, 1);
    add(1, 8'h34, 8'h00, 0, 0, 1, 1, 1, 8'h34, 0, 0, 0);
    add(1, 8'h34, 8'h00, 0, 0, 1, 1, 0, 8'h34, 0, 0, 0);

    @(posedge CLK); #1;
    foreach (vt[i]) run_vec(vt[i], i);

    // Reset arriving mid-operation: build SP=3 with STK_OVF=1, then reset with CALL pending.
    vt.delete();
    add(1, 8'h01, 8'h80, 0, 1, 0, 0, 0, 8'h80, 1, 0, 0);
    add(1, 8'h02, 8'h80, 0, 1, 0, 0, 0, 8'h80, 2, 0, 0);
    add(1, 8'h03, 8'h80, 0, 1, 0, 0, 0, 8'h80, 3, 0, 0);
    add(1, 8'h04, 8'h80, 0, 1, 0, 0, 0, 8'h80, 4, 0, 0);
    add(1, 8'h05, 8'h80, 0, 1, 0, 0, 0, 8'h80, 4, 1, 0);
    add(1, 8'h80, 8'h00, 0, 0, 1, 0, 0, 8'h05, 3, 1, 0);
    add(0, 8'h20, 8'h80, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h08, 8'h00, 0, 0, 1, 0, 0, 8'h09, 0, 0, 1);
    foreach (vt[i]) run_vec(vt[i], 100 + i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
